// File: rtl/cpu_pkg.sv
// Shared encodings for the fetch-side sequencer and control_logic:
// PC-select codes, fetch/execute state values and instruction field positions.
package cpu_pkg;

    localparam int INSTR_W = 16;

    typedef logic [1:0] pc_sel_t;

    localparam pc_sel_t PS_HOLD = 2'b00;
    localparam pc_sel_t PS_INC  = 2'b01;
    localparam pc_sel_t PS_BR   = 2'b10;
    localparam pc_sel_t PS_RET  = 2'b11;

    localparam logic ST_FETCH = 1'b0;
    localparam logic ST_EXEC  = 1'b1;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int DA_MSB  = 11;
    localparam int DA_LSB  = 8;
    localparam int AA_MSB  = 7;
    localparam int AA_LSB  = 4;
    localparam int BA_MSB  = 3;
    localparam int BA_LSB  = 0;
    localparam int OFF_MSB = 7;
    localparam int OFF_LSB = 0;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the contents alone; both conditions raise sticky flags.
module return_addr_stack
    import cpu_pkg::*;
#(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          ovf,
    output logic          unf
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = $clog2(RAS_DEPTH + 1);

    logic [AW-1:0] r_mem [RAS_DEPTH];
    logic [PW-1:0] r_ptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_unf;

    assign empty = (r_count == '0);
    assign full  = (r_count == CW'(RAS_DEPTH));
    assign dout  = r_mem[r_ptr - PW'(1)];
    assign ovf   = r_ovf;
    assign unf   = r_unf;

    // r_ptr is the next write slot; when full it also points at the oldest entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_ptr   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (push) begin
            r_mem[r_ptr] <= din;
            r_ptr        <= r_ptr + PW'(1);
            if (full) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end else if (pop) begin
            if (empty) begin
                r_unf <= 1'b1;
            end else begin
                r_ptr   <= r_ptr - PW'(1);
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pc_ir_unit.sv
// Fetch-side sequencer: PC, instruction register, fetch/execute toggle and the
// return-address stack used by jump-and-link / return.
module pc_ir_unit
    import cpu_pkg::*;
#(
    parameter int AW        = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               IL,
    input  logic [1:0]         PS,
    input  logic               LS,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               state,
    output logic [AW-1:0]      PC,
    output logic [3:0]         opcode,
    output logic [3:0]         DA,
    output logic [3:0]         AA,
    output logic [3:0]         BA,
    output logic [7:0]         offset,
    output logic               ras_ovf,
    output logic               ras_unf
);

    logic               r_state;
    logic [AW-1:0]      r_pc;
    logic [INSTR_W-1:0] r_ir;

    logic               w_exec;
    logic               w_push;
    logic               w_pop;
    logic [AW-1:0]      w_pc_inc;
    logic [AW-1:0]      w_off_ext;
    logic [AW-1:0]      w_pc_next;
    logic [AW-1:0]      w_ras_dout;
    logic               w_ras_empty;
    logic               w_ras_full_unused;

    assign w_exec    = (r_state == ST_EXEC);
    assign w_push    = w_exec && (PS == PS_BR) && LS;
    assign w_pop     = w_exec && (PS == PS_RET);
    assign w_pc_inc  = r_pc + AW'(1);
    assign w_off_ext = AW'($signed(r_ir[OFF_MSB:OFF_LSB]));

    // PC only moves on the edge that closes an execute cycle.
    always_comb begin
        w_pc_next = r_pc;
        if (w_exec) begin
            case (PS)
                PS_INC:  w_pc_next = w_pc_inc;
                PS_BR:   w_pc_next = r_pc + w_off_ext;
                PS_RET:  w_pc_next = w_ras_empty ? w_pc_inc : w_ras_dout;
                default: w_pc_next = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
        end else begin
            r_state <= ~r_state;
            r_pc    <= w_pc_next;
            if (!w_exec && IL) begin
                r_ir <= instr_in;
            end
        end
    end

    return_addr_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_pc_inc),
        .dout  (w_ras_dout),
        .empty (w_ras_empty),
        .full  (w_ras_full_unused),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    assign state  = r_state;
    assign PC     = r_pc;
    assign opcode = r_ir[OP_MSB:OP_LSB];
    assign DA     = r_ir[DA_MSB:DA_LSB];
    assign AA     = r_ir[AA_MSB:AA_LSB];
    assign BA     = r_ir[BA_MSB:BA_LSB];
    assign offset = r_ir[OFF_MSB:OFF_LSB];

endmodule

// File: tb/tb_pc_ir_unit.sv
// Testbench for pc_ir_unit: directed vector table for the fetch/branch/call/return
// corner cases, then random cycles compared against a queue-based reference model.
module tb_pc_ir_unit;

    localparam int AW        = 8;
    localparam int RAS_DEPTH = 4;
    localparam int PC_MASK   = (1 << AW) - 1;

    logic        clk;
    logic        reset;
    logic        IL;
    logic [1:0]  PS;
    logic        LS;
    logic [15:0] instr_in;
    logic        state;
    logic [7:0]  PC;
    logic [3:0]  opcode;
    logic [3:0]  DA;
    logic [3:0]  AA;
    logic [3:0]  BA;
    logic [7:0]  offset;
    logic        ras_ovf;
    logic        ras_unf;

    int checks   = 0;
    int failures = 0;

    int          m_pc;
    logic [15:0] m_ir;
    logic        m_state;
    logic        m_ovf;
    logic        m_unf;
    int          m_stack[$];

    typedef struct {
        logic        rst;
        logic        il;
        logic [1:0]  ps;
        logic        ls;
        logic [15:0] instr;
        logic        est;
        logic [7:0]  epc;
        logic [15:0] eir;
        logic        eovf;
        logic        eunf;
    } vec_t;

    vec_t vecs[$];

    pc_ir_unit #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .IL       (IL),
        .PS       (PS),
        .LS       (LS),
        .instr_in (instr_in),
        .state    (state),
        .PC       (PC),
        .opcode   (opcode),
        .DA       (DA),
        .AA       (AA),
        .BA       (BA),
        .offset   (offset),
        .ras_ovf  (ras_ovf),
        .ras_unf  (ras_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelStep(input logic rst, input logic il, input logic [1:0] ps,
                             input logic ls, input logic [15:0] instr);
        int off;
        if (rst) begin
            m_pc    = 0;
            m_ir    = 16'h0000;
            m_state = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            m_stack.delete();
            return;
        end
        if (!m_state) begin
            if (il) m_ir = instr;
        end else begin
            case (ps)
                2'd1: m_pc = (m_pc + 1) & PC_MASK;
                2'd2: begin
                    if (ls) begin
                        m_stack.push_back((m_pc + 1) & PC_MASK);
                        if (m_stack.size() > RAS_DEPTH) begin
                            m_stack.delete(0);
                            m_ovf = 1'b1;
                        end
                    end
                    off = int'(m_ir[7:0]);
                    if (off > 127) off = off - 256;
                    m_pc = (m_pc + off) & PC_MASK;
                end
                2'd3: begin
                    if (m_stack.size() == 0) begin
                        m_pc  = (m_pc + 1) & PC_MASK;
                        m_unf = 1'b1;
                    end else begin
                        m_pc = m_stack.pop_back();
                    end
                end
                default: ;
            endcase
        end
        m_state = !m_state;
    endtask

    task automatic applyStimulus(input logic rst, input logic il, input logic [1:0] ps,
                                 input logic ls, input logic [15:0] instr);
        reset    = rst;
        IL       = il;
        PS       = ps;
        LS       = ls;
        instr_in = instr;
        @(posedge clk);
        modelStep(rst, il, ps, ls, instr);
        #1;
    endtask

    task automatic checkField(input string name, input int idx, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input int idx, input logic est, input int epc,
                               input logic [15:0] eir, input logic eovf, input logic eunf);
        checkField({tag, ".state"},  idx, int'(state),   int'(est));
        checkField({tag, ".PC"},     idx, int'(PC),      epc);
        checkField({tag, ".opcode"}, idx, int'(opcode),  int'(eir[15:12]));
        checkField({tag, ".DA"},     idx, int'(DA),      int'(eir[11:8]));
        checkField({tag, ".AA"},     idx, int'(AA),      int'(eir[7:4]));
        checkField({tag, ".BA"},     idx, int'(BA),      int'(eir[3:0]));
        checkField({tag, ".offset"}, idx, int'(offset),  int'(eir[7:0]));
        checkField({tag, ".ovf"},    idx, int'(ras_ovf), int'(eovf));
        checkField({tag, ".unf"},    idx, int'(ras_unf), int'(eunf));
    endtask

    task automatic addVec(input logic rst, input logic il, input logic [1:0] ps, input logic ls,
                          input logic [15:0] instr, input logic est, input logic [7:0] epc,
                          input logic [15:0] eir, input logic eovf, input logic eunf);
        vec_t v;
        v.rst = rst; v.il = il; v.ps = ps; v.ls = ls; v.instr = instr;
        v.est = est; v.epc = epc; v.eir = eir; v.eovf = eovf; v.eunf = eunf;
        vecs.push_back(v);
    endtask

    initial begin
        reset    = 1'b1;
        IL       = 1'b0;
        PS       = 2'd0;
        LS       = 1'b0;
        instr_in = 16'h0000;

        // Reset, plain fetch/execute loop, ignored IL in execute and ignored PS/LS in fetch
        addVec(1'b1, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 2'd0, 1'b0, 16'h1234, 1'b1, 8'h00, 16'h1234, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 2'd1, 1'b0, 16'hFFFF, 1'b0, 8'h01, 16'h1234, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 2'd1, 1'b1, 16'h1234, 1'b1, 8'h01, 16'h1234, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h02, 16'h1234, 1'b0, 1'b0);
        // Backward branch with wrap, then two increments through FF to 00
        addVec(1'b0, 1'b1, 2'd0, 1'b0, 16'h00FC, 1'b1, 8'h02, 16'h00FC, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 1'b0, 8'hFE, 16'h00FC, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'hFE, 16'h00FC, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b0, 8'hFF, 16'h00FC, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'hFF, 16'h00FC, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h00FC, 1'b0, 1'b0);
        // Reach PC=5, then call +10 and return
        addVec(1'b0, 1'b1, 2'd0, 1'b0, 16'h0005, 1'b1, 8'h00, 16'h0005, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b0, 16'h0000, 1'b0, 8'h05, 16'h0005, 1'b0, 1'b0);
        addVec(1'b0, 1'b1, 2'd0, 1'b0, 16'h000A, 1'b1, 8'h05, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h0F, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b1, 8'h0F, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h06, 16'h000A, 1'b0, 1'b0);
        // Five calls overflow a depth-4 stack
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h06, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h10, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h10, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h1A, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h1A, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h24, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h24, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h2E, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h2E, 16'h000A, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd2, 1'b1, 16'h0000, 1'b0, 8'h38, 16'h000A, 1'b1, 1'b0);
        // Four returns newest first, fifth underflows
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h38, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h2F, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h2F, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h25, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h25, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h1B, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h1B, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h11, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h11, 16'h000A, 1'b1, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h12, 16'h000A, 1'b1, 1'b1);
        // Reset in execute with a pending branch, then an empty-stack return
        addVec(1'b0, 1'b1, 2'd0, 1'b0, 16'h00FC, 1'b1, 8'h12, 16'h00FC, 1'b1, 1'b1);
        addVec(1'b1, 1'b0, 2'd2, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd0, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 2'd3, 1'b0, 16'h0000, 1'b0, 8'h01, 16'h0000, 1'b0, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].il, vecs[i].ps, vecs[i].ls, vecs[i].instr);
            checkOutput("vec", i, vecs[i].est, int'(vecs[i].epc), vecs[i].eir,
                        vecs[i].eovf, vecs[i].eunf);
        end

        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 16'h0000);
        checkOutput("rand_reset", 0, m_state, m_pc, m_ir, m_ovf, m_unf);
        for (int n = 0; n < 600; n++) begin
            logic        r_rst;
            logic        r_il;
            logic [1:0]  r_ps;
            logic        r_ls;
            logic [15:0] r_instr;
            r_rst   = ($urandom_range(0, 79) == 0);
            r_il    = 1'($urandom_range(0, 3) != 0);
            r_ps    = 2'($urandom_range(0, 3));
            r_ls    = 1'($urandom_range(0, 1));
            r_instr = 16'($urandom);
            applyStimulus(r_rst, r_il, r_ps, r_ls, r_instr);
            checkOutput("rand", n, m_state, m_pc, m_ir, m_ovf, m_unf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
